prefetcher_data_path: RTL

- Entry queue of the AXI read prefetcher, directly downstream of the prefetcher controller.
- Executes one opcode per cycle from the controller: prefetch request push, master request match/push, DDR data fill, data release to NVDLA.
- Returns status to the controller: address hit, read-data ready, outstanding, count, almost-full.
- Circular buffer of 2^LOG_QUEUE_SIZE entries. Each entry holds addr, data, dataValid and promised.

---
 rtl/prefetcher_pkg.sv | 17 +
 rtl/prefetcher_entry_match.sv | 34 +++
 rtl/prefetcher_data_path.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/prefetcher_pkg.sv
// Shared types for the AXI read prefetcher: controller opcodes and per-entry status flags.
package prefetcher_pkg;

    typedef enum logic [2:0] {
        NOP               = 3'd0,
        READ_REQ_PREF     = 3'd1,
        READ_REQ_MASTER   = 3'd2,
        READ_DATA_SLAVE   = 3'd3,
        READ_DATA_PROMISE = 3'd4
    } pr_opcode_t;

    typedef struct packed {
        logic dataValid;
        logic promised;
    } pr_entry_flags_t;

endpackage

// File: rtl/prefetcher_entry_match.sv
// Age-priority address match: reports the oldest occupied, unpromised entry
// whose address equals the lookup address, scanning forward from head.
module prefetcher_entry_match #(
    parameter int ADDR_BITS      = 64,
    parameter int LOG_QUEUE_SIZE = 6
) (
    input  logic [(2**LOG_QUEUE_SIZE)-1:0][ADDR_BITS-1:0] addrs_i,
    input  logic [(2**LOG_QUEUE_SIZE)-1:0]                occupied_i,
    input  logic [(2**LOG_QUEUE_SIZE)-1:0]                promised_i,
    input  logic [LOG_QUEUE_SIZE-1:0]                     head_i,
    input  logic [ADDR_BITS-1:0]                          reqAddr_i,
    output logic                                          hit_o,
    output logic [LOG_QUEUE_SIZE-1:0]                     idx_o
);

    localparam int N = 2 ** LOG_QUEUE_SIZE;

    logic [LOG_QUEUE_SIZE-1:0] probe;

    // Scan youngest to oldest so the last match written is the oldest one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        probe = '0;
        for (int k = N - 1; k >= 0; k--) begin
            probe = head_i + LOG_QUEUE_SIZE'(k);
            if (occupied_i[probe] && !promised_i[probe] && (addrs_i[probe] == reqAddr_i)) begin
                hit_o = 1'b1;
                idx_o = probe;
            end
        end
    end

endmodule

// File: rtl/prefetcher_data_path.sv
// Entry queue of the AXI read prefetcher: circular buffer of prefetched and
// master-requested reads, filled in order by DDR and released to NVDLA.
module prefetcher_data_path
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS      = 64,
    parameter int LOG_QUEUE_SIZE = 6,
    parameter int DATA_WIDTH     = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pr_flush,
    input  logic [2:0]              pr_opCode,
    input  logic [ADDR_BITS-1:0]    pr_reqAddr,
    input  logic [DATA_WIDTH-1:0]   m_r_data,
    output logic [DATA_WIDTH-1:0]   s_r_data,
    output logic                    pr_addrHit,
    output logic                    pr_r_valid,
    output logic                    pr_hasOutstanding,
    output logic [LOG_QUEUE_SIZE:0] pr_reqCnt,
    output logic                    pr_almostFull,
    output logic                    pr_err
);

    localparam int N = 2 ** LOG_QUEUE_SIZE;
    localparam logic [LOG_QUEUE_SIZE:0] MAX_CNT    = {1'b1, {LOG_QUEUE_SIZE{1'b0}}};
    localparam logic [LOG_QUEUE_SIZE:0] ALMOST_CNT = MAX_CNT - 1'b1;

    logic [LOG_QUEUE_SIZE-1:0]          head_q, head_d, fill_q, fill_d, tail_q, tail_d;
    logic [LOG_QUEUE_SIZE:0]            count_q, count_d;
    logic                               err_q, err_d;
    logic [DATA_WIDTH-1:0]              sData_q, sData_d;
    pr_entry_flags_t                    flags_q [N];
    logic [N-1:0][ADDR_BITS-1:0]        addr_q;
    logic [DATA_WIDTH-1:0]              data_q [N];

    logic [N-1:0]                       occupied, promisedVec;
    logic [LOG_QUEUE_SIZE-1:0]          offset;
    logic                               isFull, rValid, hasOut, hit;
    logic [LOG_QUEUE_SIZE-1:0]          hitIdx;
    logic                               pushEn, pushPromised, fillEn, promEn, relEn, setErr;

    always_comb begin
        occupied    = '0;
        promisedVec = '0;
        offset      = '0;
        for (int i = 0; i < N; i++) begin
            offset         = LOG_QUEUE_SIZE'(i) - head_q;
            occupied[i]    = {1'b0, offset} < count_q;
            promisedVec[i] = flags_q[i].promised;
        end
    end

    prefetcher_entry_match #(
        .ADDR_BITS      (ADDR_BITS),
        .LOG_QUEUE_SIZE (LOG_QUEUE_SIZE)
    ) u_match (
        .addrs_i    (addr_q),
        .occupied_i (occupied),
        .promised_i (promisedVec),
        .head_i     (head_q),
        .reqAddr_i  (pr_reqAddr),
        .hit_o      (hit),
        .idx_o      (hitIdx)
    );

    // When full, fill == tail is ambiguous; the entry under fill tells whether
    // everything is still waiting (not yet valid) or everything has arrived.
    assign isFull = (count_q == MAX_CNT);
    assign rValid = flags_q[head_q].promised && flags_q[head_q].dataValid;
    assign hasOut = (fill_q != tail_q) || (isFull && !flags_q[fill_q].dataValid);

    always_comb begin
        pushEn       = 1'b0;
        pushPromised = 1'b0;
        fillEn       = 1'b0;
        promEn       = 1'b0;
        relEn        = 1'b0;
        setErr       = 1'b0;
        if (!pr_flush) begin
            case (pr_opCode)
                READ_REQ_PREF: begin
                    if (!isFull) pushEn = 1'b1;
                    else         setErr = 1'b1;
                end
                READ_REQ_MASTER: begin
                    if (hit) begin
                        promEn = 1'b1;
                    end else if (!isFull) begin
                        pushEn       = 1'b1;
                        pushPromised = 1'b1;
                    end else begin
                        setErr = 1'b1;
                    end
                end
                READ_DATA_SLAVE: begin
                    if (hasOut) fillEn = 1'b1;
                    else        setErr = 1'b1;
                end
                READ_DATA_PROMISE: begin
                    if (rValid) relEn  = 1'b1;
                    else        setErr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        head_d  = relEn  ? head_q + 1'b1 : head_q;
        fill_d  = fillEn ? fill_q + 1'b1 : fill_q;
        tail_d  = pushEn ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({pushEn, relEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
        err_d   = err_q | setErr;
        sData_d = relEn ? data_q[head_q] : sData_q;
        if (pr_flush) begin
            head_d  = '0;
            fill_d  = '0;
            tail_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            fill_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            sData_q <= '0;
        end else begin
            head_q  <= head_d;
            fill_q  <= fill_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
            sData_q <= sData_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) flags_q[i] <= '0;
        end else if (pr_flush) begin
            for (int i = 0; i < N; i++) flags_q[i] <= '0;
        end else begin
            if (pushEn) flags_q[tail_q]           <= '{dataValid: 1'b0, promised: pushPromised};
            if (fillEn) flags_q[fill_q].dataValid <= 1'b1;
            if (promEn) flags_q[hitIdx].promised  <= 1'b1;
            if (relEn)  flags_q[head_q]           <= '0;
        end
    end

    // Payload storage needs no reset; only occupied entries with valid flags are ever used.
    always_ff @(posedge clk) begin
        if (pushEn) addr_q[tail_q] <= pr_reqAddr;
        if (fillEn) data_q[fill_q] <= m_r_data;
    end

    assign s_r_data          = sData_q;
    assign pr_addrHit        = hit;
    assign pr_r_valid        = rValid;
    assign pr_hasOutstanding = hasOut;
    assign pr_reqCnt         = count_q;
    assign pr_almostFull     = (count_q >= ALMOST_CNT);
    assign pr_err            = err_q;

endmodule
